// File: rtl/fpu_pkg.sv
// Shared definitions for the FP conversion blocks: FSM state encoding and
// IEEE-754 / int32 constants.
package fpu_pkg;

  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    GET_A_LO = 3'd1,
    UNPACK   = 3'd2,
    SPECIAL  = 3'd3,
    CONVERT  = 3'd4,
    PUT_Z    = 3'd5,
    PUT_Z_LO = 3'd6
  } f2i_state_t;

  localparam int          FP32_EXP_BIAS = 127;
  localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational split of an IEEE-754 single into sign, unbiased exponent and
// a left-justified 32-bit mantissa with the hidden one made explicit.
module fp32_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]       a,
  output logic              s,
  output logic signed [9:0] e,
  output logic [31:0]       m
);

  // Field extraction; exponent is widened before unbiasing so -127..128 fits.
  always_comb begin
    s = a[31];
    e = $signed({2'b00, a[30:23]}) - 10'(FP32_EXP_BIAS);
    m = {1'b1, a[22:0], 8'b0};
  end

endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single to int32 converter, truncating toward zero, with 16-bit
// two-word (high word first) strobe/ack streams on both sides.
// Optional macro FLOAT_TO_INT_SATURATE_EN: NaN returns 0, positive
// overflow/+inf saturates to INT32_MAX, negative to INT32_MIN. Without it every
// out-of-range input and NaN returns INT32_MIN.
module float_to_int
  import fpu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [15:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  f2i_state_t        state_reg, state_next;
  logic [31:0]       a_reg, a_next;
  logic              s_reg, s_next;
  logic signed [9:0] e_reg, e_next;
  logic [31:0]       m_reg, m_next;
  logic [31:0]       z_reg, z_next;
  logic              ack_reg, ack_next;
  logic              stb_reg, stb_next;
  logic [15:0]       out_reg, out_next;

  logic              u_s;
  logic signed [9:0] u_e;
  logic [31:0]       u_m;

  logic signed [9:0] remaining;
  logic signed [9:0] amt;
  logic signed [9:0] e_shifted;
  logic [31:0]       m_shifted;

  fp32_unpack u_unpack (
    .a (a_reg),
    .s (u_s),
    .e (u_e),
    .m (u_m)
  );

  // Shift amount for this CONVERT cycle: never overshoot e == 31.
  always_comb begin
    remaining = 10'sd31 - e_reg;
    amt       = (remaining < 10'(SHIFT_STEP)) ? remaining : 10'(SHIFT_STEP);
    m_shifted = m_reg >> amt;
    e_shifted = e_reg + amt;
  end

  // Next-state and registered-output logic; handshakes are registered so
  // ack/stb rise one cycle after their state is entered.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    s_next     = s_reg;
    e_next     = e_reg;
    m_next     = m_reg;
    z_next     = z_reg;
    ack_next   = ack_reg;
    stb_next   = stb_reg;
    out_next   = out_reg;
    case (state_reg)
      GET_A: begin
        ack_next = 1'b1;
        if (input_a_stb && ack_reg) begin
          a_next[31:16] = input_a;
          ack_next      = 1'b0;
          state_next    = GET_A_LO;
        end
      end
      GET_A_LO: begin
        ack_next = 1'b1;
        if (input_a_stb && ack_reg) begin
          a_next[15:0] = input_a;
          ack_next     = 1'b0;
          state_next   = UNPACK;
        end
      end
      UNPACK: begin
        s_next     = u_s;
        e_next     = u_e;
        m_next     = u_m;
        state_next = SPECIAL;
      end
      SPECIAL: begin
        if (e_reg == -10'sd127) begin
          z_next     = 32'd0;
          state_next = PUT_Z;
        end else if (e_reg > 10'sd30) begin
`ifdef FLOAT_TO_INT_SATURATE_EN
          if ((e_reg == 10'sd128) && (m_reg[30:8] != 23'd0))
            z_next = 32'd0;
          else
            z_next = s_reg ? INT32_MIN : INT32_MAX;
`else
          z_next = INT32_MIN;
`endif
          state_next = PUT_Z;
        end else begin
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        m_next = m_shifted;
        e_next = e_shifted;
        // Result is formed on the same cycle as the final shift.
        if (e_shifted == 10'sd31) begin
          z_next     = s_reg ? -m_shifted : m_shifted;
          state_next = PUT_Z;
        end
      end
      PUT_Z: begin
        stb_next = 1'b1;
        out_next = z_reg[31:16];
        if (stb_reg && output_z_ack) begin
          stb_next   = 1'b0;
          state_next = PUT_Z_LO;
        end
      end
      PUT_Z_LO: begin
        stb_next = 1'b1;
        out_next = z_reg[15:0];
        if (stb_reg && output_z_ack) begin
          stb_next   = 1'b0;
          state_next = GET_A;
        end
      end
      default: begin
        state_next = GET_A;
        ack_next   = 1'b0;
        stb_next   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= GET_A;
      a_reg     <= 32'd0;
      s_reg     <= 1'b0;
      e_reg     <= 10'sd0;
      m_reg     <= 32'd0;
      z_reg     <= 32'd0;
      ack_reg   <= 1'b0;
      stb_reg   <= 1'b0;
      out_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      s_reg     <= s_next;
      e_reg     <= e_next;
      m_reg     <= m_next;
      z_reg     <= z_next;
      ack_reg   <= ack_next;
      stb_reg   <= stb_next;
      out_reg   <= out_next;
    end
  end

  assign input_a_ack  = ack_reg;
  assign output_z_stb = stb_reg;
  assign output_z     = out_reg;

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed floats, a value model of
// truncating conversion, CONVERT-length checks, output stall and reset abort.
module tb_float_to_int;

  localparam int SHIFT_STEP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [15:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  float_to_int #(.SHIFT_STEP(SHIFT_STEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  // Value of the float as an integer, truncated toward zero.
  function automatic logic [31:0] model(input logic [31:0] f);
    int          ex;
    logic [63:0] mag;
    logic [31:0] r;
    ex = int'(f[30:23]) - 127;
    if (f[30:23] == 8'd0) return 32'd0;
    if (ex > 30) begin
`ifdef FLOAT_TO_INT_SATURATE_EN
      if (f[30:23] == 8'hFF && f[22:0] != 23'd0) return 32'd0;
      return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
      return 32'h8000_0000;
`endif
    end
    mag = {40'd0, 1'b1, f[22:0]};
    if (ex >= 23) mag = mag << (ex - 23);
    else          mag = mag >> (23 - ex);
    r = mag[31:0];
    return f[31] ? -r : r;
  endfunction

  // Expected CONVERT duration; special-path inputs skip CONVERT entirely.
  function automatic int conv_cycles(input logic [31:0] f);
    int ex;
    ex = int'(f[30:23]) - 127;
    if (f[30:23] == 8'd0 || ex > 30) return 0;
    return (31 - ex + SHIFT_STEP - 1) / SHIFT_STEP;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare process: assembles output words, checks results and stall hold.
  initial begin
    int          idx = 0;
    logic [15:0] hi = 16'd0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_val = 16'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idx = 0;
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check("hold_stb", 32'(output_z_stb), 32'd1);
        check("hold_data", 32'(output_z), 32'(prev_val));
      end
      if (output_z_stb && output_z_ack) begin
        if (idx == 0) begin
          hi  = output_z;
          idx = 1;
        end else begin
          idx = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_output", {hi, output_z}, 32'hxxxx_xxxx);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("result", {hi, output_z}, e);
            $display("result %h expected %h", {hi, output_z}, e);
          end
        end
      end
      prev_hold = output_z_stb && !output_z_ack;
      prev_val  = output_z;
    end
  end

  // Wait for input_a_ack at a negedge (transfer on the following posedge).
  task automatic wait_ack(output bit ok);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!input_a_ack && t < 500);
    ok = input_a_ack;
    if (!ok) check("input_ack_timeout", 32'(input_a_ack), 32'd1);
  endtask

  task automatic send(input logic [31:0] f, input bit measure);
    bit ok;
    int n;
    input_a     = f[31:16];
    input_a_stb = 1'b1;
    wait_ack(ok);
    if (!ok) begin input_a_stb = 1'b0; return; end
    @(posedge clk); #1;
    input_a = f[15:0];
    wait_ack(ok);
    if (!ok) begin input_a_stb = 1'b0; return; end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    exp_q.push_back(model(f));
    if (measure) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!output_z_stb && n < 500);
      check($sformatf("latency_%h", f), 32'(n), 32'(3 + conv_cycles(f)));
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] vecs[17] = '{
    32'h40490FDB, 32'hC0200000, 32'h4F000000, 32'h7FC00000, 32'h00000001,
    32'h3F800000, 32'h00000000, 32'h80000000, 32'hCF000000, 32'h4EFFFFFF,
    32'hCEFFFFFF, 32'h3F000000, 32'hFF800000, 32'h7F800000, 32'h42F6E979,
    32'hC2F6E979, 32'h4B000000
  };

  initial begin
    rst          = 1'b1;
    input_a      = 16'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(input_a_ack), 32'd0);
    check("reset_stb", 32'(output_z_stb), 32'd0);
    check("reset_z", 32'(output_z), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand-computed values that pin the model.
    check("model_pi", model(32'h40490FDB), 32'h0000_0003);
    check("model_m2p5", model(32'hC0200000), 32'hFFFF_FFFE);
    check("model_one", model(32'h3F800000), 32'h0000_0001);
    check("model_denorm", model(32'h00000001), 32'h0000_0000);
    check("model_big", model(32'h4EFFFFFF), 32'h7FFF_FF80);
    check("model_m123", model(32'hC2F6E979), 32'hFFFF_FF85);
`ifdef FLOAT_TO_INT_SATURATE_EN
    check("model_2p31", model(32'h4F000000), 32'h7FFF_FFFF);
    check("model_nan", model(32'h7FC00000), 32'h0000_0000);
`else
    check("model_2p31", model(32'h4F000000), 32'h8000_0000);
    check("model_nan", model(32'h7FC00000), 32'h8000_0000);
`endif
    check("cycles_one", 32'(conv_cycles(32'h3F800000)), (SHIFT_STEP == 4) ? 32'd8 : 32'd31);

    // Directed vectors, sink always ready.
    foreach (vecs[i]) send(vecs[i], 1'b1);
    drain();

    // Output stall: hold ack low for 5 cycles while stb is up.
    output_z_ack = 1'b0;
    send(32'h40490FDB, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("stall_stb", 32'(output_z_stb), 32'd1);
      check("stall_z", 32'(output_z), 32'h0000);
      check("stall_in_ack", 32'(input_a_ack), 32'd0);
    end
    @(posedge clk); #1;
    output_z_ack = 1'b1;
    drain();

    // Reset during CONVERT, then a clean conversion.
    send(32'h3F800000, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_conv_ack", 32'(input_a_ack), 32'd0);
    check("abort_conv_stb", 32'(output_z_stb), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h3F800000, 1'b1);
    drain();

    // Reset while the output is stalled with stb high.
    output_z_ack = 1'b0;
    send(32'hC0200000, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_put_stb", 32'(output_z_stb), 32'd0);
    check("abort_put_z", 32'(output_z), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    output_z_ack = 1'b1;
    send(32'h42F6E979, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
